// File: rtl/spi_pkg.sv
// Shared SPI link definitions: command codes, master state encoding and
// default frame geometry used by the master, slave and RAM.
package spi_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SPI_FRAME_W = SPI_DATA_W + 2;

    typedef enum logic [1:0] {
        SPI_WR_ADDR = 2'b00,
        SPI_WR_DATA = 2'b01,
        SPI_RD_ADDR = 2'b10,
        SPI_RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        M_IDLE      = 3'd0,
        M_LEAD      = 3'd1,
        M_SHIFT_OUT = 3'd2,
        M_TURN      = 3'd3,
        M_SHIFT_IN  = 3'd4,
        M_GAP       = 3'd5
    } master_state_e;

    function automatic int spi_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_master.sv
// SPI initiator: serialises one {cmd, payload} frame per accepted command and,
// for RD_DATA, collects the slave's reply byte after a turnaround slot.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int FRAME_W     = SPI_FRAME_W,
    parameter int LEAD_CYCLES = 1,
    parameter int TURN_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [DATA_W-1:0] cmd_payload,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int CNT_MAX = spi_max(spi_max(FRAME_W, DATA_W),
                                     spi_max(spi_max(LEAD_CYCLES, TURN_CYCLES), GAP_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    master_state_e      state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [FRAME_W-1:0] tx, tx_next;
    logic [DATA_W-2:0]  rx;
    logic               rd, rd_next;
    logic               last;
    logic               ss_n_next, mosi_next, rsp_fire;

    // Counter reload value on entry: the state then lasts (value + 1) cycles.
    function automatic logic [CNT_W-1:0] state_len(input master_state_e s);
        case (s)
            M_LEAD:      state_len = CNT_W'(LEAD_CYCLES - 1);
            M_SHIFT_OUT: state_len = CNT_W'(FRAME_W - 1);
            M_TURN:      state_len = CNT_W'(TURN_CYCLES - 1);
            M_SHIFT_IN:  state_len = CNT_W'(DATA_W - 1);
            M_GAP:       state_len = CNT_W'(GAP_CYCLES - 1);
            default:     state_len = '0;
        endcase
    endfunction

    always_comb begin
        state_next = state;
        tx_next    = tx;
        rd_next    = rd;
        cnt_next   = cnt;
        last       = (cnt == '0);
        case (state)
            M_IDLE: begin
                if (cmd_valid) begin
                    tx_next    = FRAME_W'({cmd_type, cmd_payload});
                    rd_next    = (cmd_type == SPI_RD_DATA);
                    state_next = (LEAD_CYCLES > 0) ? M_LEAD : M_SHIFT_OUT;
                end
            end
            M_LEAD: begin
                if (last) state_next = M_SHIFT_OUT;
            end
            M_SHIFT_OUT: begin
                if (last) begin
                    if (rd) state_next = (TURN_CYCLES > 0) ? M_TURN : M_SHIFT_IN;
                    else    state_next = M_GAP;
                end else begin
                    tx_next = {tx[FRAME_W-2:0], 1'b0};
                end
            end
            M_TURN: begin
                if (last) state_next = M_SHIFT_IN;
            end
            M_SHIFT_IN: begin
                if (last) state_next = M_GAP;
            end
            M_GAP: begin
                if (last) state_next = M_IDLE;
            end
            default: state_next = M_IDLE;
        endcase

        // Reload on every state change; otherwise count down and park at zero.
        if (state_next != state)
            cnt_next = state_len(state_next);
        else if (!last)
            cnt_next = cnt - 1'b1;
    end

    // SS_n/MOSI are registered from the next state so they line up with it.
    assign ss_n_next = (state_next == M_IDLE) || (state_next == M_GAP);
    assign mosi_next = (state_next == M_SHIFT_OUT) ? tx_next[FRAME_W-1] : 1'b0;
    assign rsp_fire  = (state == M_SHIFT_IN) && (state_next == M_GAP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= M_IDLE;
            cnt       <= '0;
            rd        <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rd        <= rd_next;
            SS_n      <= ss_n_next;
            MOSI      <= mosi_next;
            rsp_valid <= rsp_fire;
            if (rsp_fire) rsp_data <= {rx, MISO};
        end
    end

    always_ff @(posedge clk) begin
        tx <= tx_next;
        if (state == M_SHIFT_IN) rx <= {rx[DATA_W-3:0], MISO};
    end

    assign cmd_ready = (state == M_IDLE);
    assign busy      = !cmd_ready;

endmodule
